key_debounce: RTL
=================

Name: key_debounce

Overview:
- Input conditioning stage directly upstream of the user-key bus slave.
- Takes the 8 raw, asynchronous board push-buttons and synchronizes them to `clk`, then debounces each one independently.
- Presents clean levels on `user_key`, which feed the key register's 8-bit input unchanged.
- Also produces one-cycle press pulses and sticky, software-clearable press flags, so the CPU side can catch short presses between polls.

Parameters:
- N_KEYS, 8, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a level is accepted (20 ms at 50 MHz). Legal range 2..2^CNT_W.
- CNT_W, 20, width of each per-key stability counter. Must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, raw key polarity. 1 means pressed = 0, idle = 1.

Ports:
- clk  in  1  system clock.
- sys_rstn  in  1  reset, asynchronous assert, active-low.
- key_raw  in  N_KEYS  raw pad inputs, asynchronous to clk.
- user_key  out  N_KEYS  debounced level, same polarity as key_raw; drives the key register input.
- press_pulse  out  N_KEYS  active-high, one clk cycle per accepted press.
- release_pulse  out  N_KEYS  active-high, one clk cycle per accepted release.
- press_flag  out  N_KEYS  sticky active-high "pressed since last clear".
- flag_clr  in  N_KEYS  per-key synchronous clear of press_flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (`clk`, `sys_rstn`).
- Reset (sys_rstn=0, immediate, independent of clk):
  - sync flops and `user_key` go to the idle level: all 1s if ACTIVE_LOW=1, all 0s otherwise;
  - counters cleared;
  - press_pulse, release_pulse and press_flag are all 0.
- Reset mid-operation: any in-progress count is discarded. After release, a key held down is re-accepted after the full latency.
- Synchronizer: two flops per key (sync1 → sync2). No logic between them.
- Per-key debounce, evaluated each cycle:
  - if sync2 == user_key[i]: cnt[i] <= 0.
  - else if cnt[i] == DEBOUNCE_CYCLES-1: user_key[i] <= sync2 and cnt[i] <= 0.
  - else: cnt[i] <= cnt[i]+1.
- Latency: a clean raw change is visible on user_key exactly 2+DEBOUNCE_CYCLES rising edges after it is sampled into sync1.
- Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES cycles (at sync2) produces no output change. Any return to the current level restarts the count from 0.
- Pulses (registered):
  - press_pulse[i]=1 in the same cycle user_key[i] first shows the pressed level; release_pulse[i] likewise for the idle level.
  - Both are 0 in every other cycle, and are never asserted together for one key.
- press_flag[i]: set when press_pulse[i] is 1; cleared when flag_clr[i]=1.
  - Simultaneous set and clear: set wins (flag stays 1), so no press is lost.
  - flag_clr held high continuously keeps the flag clear except in cycles following a press.
- Keys are fully independent. Simultaneous events on different keys are all reported in the same cycle.
- No combinational path from any input to any output.

Decomposition:
- Shared package/header (`macro.vh`-style defines):
  - KEY_N_DEFAULT=8;
  - KEY_DEBOUNCE_DEFAULT=1000000;
  - KEY_IDLE_LEVEL, derived from ACTIVE_LOW.
- Sub-module key_debounce_cell: one key's sync pair, counter, stable level, pulse logic and flag. The top generate-instantiates N_KEYS cells.

Test Plan (sim with DEBOUNCE_CYCLES=4, CNT_W=3, ACTIVE_LOW=1):
1. Reset, then key_raw=8'hFF held → user_key=8'hFF, all pulses 0, press_flag=8'h00 for 20 cycles.
2. key_raw[0] 1→0 cleanly → user_key=8'hFE exactly 6 edges later; press_pulse=8'h01 for exactly that one cycle; press_flag=8'h01 thereafter.
3. key_raw[3] low for 3 cycles then back high → user_key stays 8'hFF and no pulse. A 4-cycle-at-sync2 low is accepted.
4. Assert flag_clr=8'h01 in the same cycle as a new press_pulse[0] → press_flag[0] stays 1. A clear one cycle later → press_flag[0]=0.
5. Release key 0 → release_pulse=8'h01 one cycle; user_key returns to 8'hFF.
6. Hold key 5 pressed and drop sys_rstn mid-count → outputs immediately idle/0. After release with the key still held, user_key=8'hDF 6 edges later, with press_pulse[5].

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared defaults and polarity helper for the user-key input conditioning path.
package key_debounce_pkg;

  localparam int KEY_N_DEFAULT        = 8;
  localparam int KEY_DEBOUNCE_DEFAULT = 1000000;
  localparam int KEY_CNT_W_DEFAULT    = 20;

  // Level a key rests at when nobody touches it.
  function automatic logic key_idle_level(input int active_low);
    return (active_low != 0);
  endfunction

  localparam logic KEY_IDLE_LEVEL = key_idle_level(1);

endpackage

// File: rtl/key_debounce_cell.sv
// One key channel: two-flop synchronizer, stability counter, accepted level,
// press/release pulses and a sticky press flag.
module key_debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = KEY_CNT_W_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic sys_rstn,
  input  logic key_raw,
  input  logic flag_clr,
  output logic user_key,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_flag
);

  localparam logic             IDLE     = key_idle_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             level_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             press_pulse_reg;
  logic             press_pulse_next;
  logic             release_pulse_reg;
  logic             release_pulse_next;
  logic             press_flag_reg;
  logic             press_flag_next;
  logic             accept;

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1_reg         <= IDLE;
      sync2_reg         <= IDLE;
      level_reg         <= IDLE;
      cnt_reg           <= '0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      press_flag_reg    <= 1'b0;
    end else begin
      sync1_reg         <= key_raw;
      sync2_reg         <= sync1_reg;
      level_reg         <= level_next;
      cnt_reg           <= cnt_next;
      press_pulse_reg   <= press_pulse_next;
      release_pulse_reg <= release_pulse_next;
      press_flag_reg    <= press_flag_next;
    end
  end

  always_comb begin
    level_next = level_reg;
    cnt_next   = '0;
    accept     = 1'b0;
    // Any cycle where the synchronized input matches the accepted level restarts the count.
    if (sync2_reg != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        accept     = 1'b1;
        level_next = sync2_reg;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
    press_pulse_next   = accept && (sync2_reg != IDLE);
    release_pulse_next = accept && (sync2_reg == IDLE);
    // A press registered this cycle outranks a clear so no press is lost.
    press_flag_next    = press_pulse_reg | (press_flag_reg & ~flag_clr);
  end

  assign user_key      = level_reg;
  assign press_pulse   = press_pulse_reg;
  assign release_pulse = release_pulse_reg;
  assign press_flag    = press_flag_reg;

endmodule

// File: rtl/key_debounce.sv
// Board push-button conditioning: N_KEYS independent synchronize+debounce channels
// feeding the user-key register, plus press/release pulses and sticky press flags.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = KEY_N_DEFAULT,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = KEY_CNT_W_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk,
  input  logic              sys_rstn,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic [N_KEYS-1:0] flag_clr,
  output logic [N_KEYS-1:0] user_key,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] press_flag
);

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      key_debounce_cell #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_cell (
        .clk           (clk),
        .sys_rstn      (sys_rstn),
        .key_raw       (key_raw[gi]),
        .flag_clr      (flag_clr[gi]),
        .user_key      (user_key[gi]),
        .press_pulse   (press_pulse[gi]),
        .release_pulse (release_pulse[gi]),
        .press_flag    (press_flag[gi])
      );
    end
  endgenerate

endmodule
